// File: rtl/dmem_sram_responder_pkg.sv
// dmem_sram_responder_pkg: shared widths, write-enable encoding and responder FSM states
package dmem_sram_responder_pkg;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [3:0] WE_READ = 4'h0;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
endpackage

// File: rtl/dmem_sram_responder_ram.sv
// dmem_sram_responder_ram: single-port byte-enable RAM with registered read output
module dmem_sram_responder_ram
    import dmem_sram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] q
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < 4; k++)
                if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            if (we == WE_READ) q <= mem[addr];
        end
    end
endmodule

// File: rtl/dmem_sram_responder.sv
// dmem_sram_responder: valid/ready data-memory responder over a local SRAM with programmable wait states
module dmem_sram_responder
    import dmem_sram_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmem_valid_i,
    output logic              dmem_ready_o,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic [WORD_W-1:0] dmem_wdata_i,
    input  logic [3:0]        dmem_we_i,
    output logic [WORD_W-1:0] dmem_rdata_o,
    output logic              dmem_err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH_WORDS * 4);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_q, err_q, accept, in_range;
    logic [ADDR_W-1:0] off;
    logic [WORD_W-1:0] ram_q, rdata_q;

    // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare covers both bounds
    assign off      = dmem_addr_i - BASE_ADDR;
    assign in_range = off < SPAN;
    assign accept   = state_q == S_IDLE && dmem_valid_i;

    dmem_sram_responder_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .en    (accept && in_range),
        .we    (dmem_we_i),
        .addr  (off[AW+1:2]),
        .wdata (dmem_wdata_i),
        .q     (ram_q)
    );

    always_comb begin
        state_d = state_q == S_IDLE ? (dmem_valid_i ? (WAIT_CYCLES > 0 ? S_WAIT : S_RESP) : S_IDLE)
                : state_q == S_WAIT ? (cnt_q == 4'd0 ? S_RESP : S_WAIT)
                : S_IDLE;
        cnt_d   = accept ? WAIT_INIT : (state_q == S_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rd_q  <= in_range && dmem_we_i == WE_READ;
                err_q <= !in_range;
            end
            if (state_q == S_RESP) rdata_q <= dmem_rdata_o;
        end
    end

    // RAM output register supplies the word during RESP; rdata_q holds it afterwards
    assign dmem_ready_o = state_q == S_RESP;
    assign dmem_err_o   = dmem_ready_o && err_q;
    assign dmem_rdata_o = dmem_ready_o ? (rd_q ? ram_q : '0) : rdata_q;
endmodule
